timer_regs: RTL and testbench

Memory-mapped 64-bit machine timer on the CPU data bus, alongside `uart_regs` in the I/O window; it decodes the same chip-select, read and write strobes. It provides a prescaled free-running `mtime` counter, a 64-bit `mtimecmp` compare register, a sticky match flag and a level timer-interrupt output toward the CPU. A snapshot latch guarantees coherent 64-bit reads over the 32-bit bus.

---
 rtl/timer_regs_pkg.sv | 20 ++
 rtl/timer_prescaler.sv | 28 ++
 rtl/timer_regs.sv | 146 ++++++++++++++
 tb/tb_timer_regs.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_regs_pkg.sv
// rtl/timer_regs_pkg.sv - register map, CTRL bit positions and reset constants for timer_regs
package timer_regs_pkg;

  localparam logic [2:0] TMR_MTIME_LO = 3'd0;
  localparam logic [2:0] TMR_MTIME_HI = 3'd1;
  localparam logic [2:0] TMR_CMP_LO   = 3'd2;
  localparam logic [2:0] TMR_CMP_HI   = 3'd3;
  localparam logic [2:0] TMR_CTRL     = 3'd4;
  localparam logic [2:0] TMR_STATUS   = 3'd5;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_IRQ_EN_BIT = 1;
  localparam int CTRL_PRESC_LSB  = 8;

  localparam int STATUS_MATCH_BIT = 0;

  // Compare register starts at its maximum so nothing matches out of reset.
  localparam logic [63:0] MTIMECMP_RST = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage

// File: rtl/timer_prescaler.sv
// rtl/timer_prescaler.sv - divide-by-(presc+1) tick generator for the machine timer
module timer_prescaler #(
  parameter int PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic [PRESC_W-1:0] presc,
  input  logic               clear,
  output logic               tick
);

  logic [PRESC_W-1:0] count;

  assign tick = enable && (count == presc);

  // Held at zero while disabled so counting restarts on a clean phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear || !enable || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/timer_regs.sv
// rtl/timer_regs.sv - memory-mapped 64-bit machine timer with compare, sticky match and irq
module timer_regs
  import timer_regs_pkg::*;
#(
  parameter int          PRESC_W   = 8,
  parameter logic [63:0] MTIME_RST = 64'd0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wr,
  input  logic        i_rd,
  input  logic        i_cs,
  input  logic [2:0]  i_addr,
  input  logic [31:0] i_data_in,
  output logic [31:0] o_data_out,
  output logic        o_irq
);

  logic [63:0]        mtime;
  logic [63:0]        mtimecmp;
  logic               ctrl_en;
  logic               ctrl_irq_en;
  logic [PRESC_W-1:0] ctrl_presc;
  logic               match;
  logic [31:0]        snap;
  logic               tick;
  logic               cmp_true;
  logic [31:0]        rd_word;

  logic wr_en, rd_en;
  logic wr_mtime_lo, wr_mtime_hi, wr_cmp_lo, wr_cmp_hi, wr_ctrl, wr_status;
  logic rd_mtime_lo;

  assign wr_en       = i_cs & i_wr;
  assign rd_en       = i_cs & i_rd;
  assign wr_mtime_lo = wr_en && (i_addr == TMR_MTIME_LO);
  assign wr_mtime_hi = wr_en && (i_addr == TMR_MTIME_HI);
  assign wr_cmp_lo   = wr_en && (i_addr == TMR_CMP_LO);
  assign wr_cmp_hi   = wr_en && (i_addr == TMR_CMP_HI);
  assign wr_ctrl     = wr_en && (i_addr == TMR_CTRL);
  assign wr_status   = wr_en && (i_addr == TMR_STATUS);
  assign rd_mtime_lo = rd_en && (i_addr == TMR_MTIME_LO);

  assign cmp_true = (mtime >= mtimecmp);

  timer_prescaler #(
    .PRESC_W (PRESC_W)
  ) u_prescaler (
    .clk    (i_clk),
    .rst_n  (i_rst),
    .enable (ctrl_en),
    .presc  (ctrl_presc),
    .clear  (wr_ctrl),
    .tick   (tick)
  );

  // A software write to either half swallows a coincident tick.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      mtime <= MTIME_RST;
    end else if (wr_mtime_lo) begin
      mtime[31:0] <= i_data_in;
    end else if (wr_mtime_hi) begin
      mtime[63:32] <= i_data_in;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      mtimecmp <= MTIMECMP_RST;
    end else begin
      if (wr_cmp_lo) mtimecmp[31:0]  <= i_data_in;
      if (wr_cmp_hi) mtimecmp[63:32] <= i_data_in;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ctrl_presc  <= '0;
    end else if (wr_ctrl) begin
      ctrl_en     <= i_data_in[CTRL_EN_BIT];
      ctrl_irq_en <= i_data_in[CTRL_IRQ_EN_BIT];
      ctrl_presc  <= i_data_in[CTRL_PRESC_LSB +: PRESC_W];
    end
  end

  // Setting beats a same-cycle W1C so a live match is never lost.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      match <= 1'b0;
    end else if (cmp_true) begin
      match <= 1'b1;
    end else if (wr_status && i_data_in[STATUS_MATCH_BIT]) begin
      match <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_irq <= 1'b0;
    end else begin
      o_irq <= ctrl_irq_en & cmp_true;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      snap <= '0;
    end else if (wr_mtime_hi) begin
      snap <= i_data_in;
    end else if (rd_mtime_lo) begin
      snap <= mtime[63:32];
    end
  end

  // MTIME_HI reads the snapshot so a LO/HI pair is coherent across carries.
  always_comb begin
    rd_word = '0;
    case (i_addr)
      TMR_MTIME_LO: rd_word = mtime[31:0];
      TMR_MTIME_HI: rd_word = snap;
      TMR_CMP_LO:   rd_word = mtimecmp[31:0];
      TMR_CMP_HI:   rd_word = mtimecmp[63:32];
      TMR_CTRL: begin
        rd_word[CTRL_EN_BIT]                 = ctrl_en;
        rd_word[CTRL_IRQ_EN_BIT]             = ctrl_irq_en;
        rd_word[CTRL_PRESC_LSB +: PRESC_W]   = ctrl_presc;
      end
      TMR_STATUS:   rd_word[STATUS_MATCH_BIT] = match;
      default:      rd_word = '0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_data_out <= '0;
    end else if (rd_en) begin
      o_data_out <= rd_word;
    end
  end

endmodule

// File: tb/tb_timer_regs.sv
// tb/tb_timer_regs.sv - scoreboard bench for timer_regs against a behavioural timer model
module tb_timer_regs;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_wr = 1'b0;
  logic        i_rd = 1'b0;
  logic        i_cs = 1'b0;
  logic [2:0]  i_addr = '0;
  logic [31:0] i_data_in = '0;
  logic [31:0] o_data_out;
  logic        o_irq;

  always #5 i_clk = ~i_clk;

  timer_regs #(
    .PRESC_W   (8),
    .MTIME_RST (64'd0)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wr       (i_wr),
    .i_rd       (i_rd),
    .i_cs       (i_cs),
    .i_addr     (i_addr),
    .i_data_in  (i_data_in),
    .o_data_out (o_data_out),
    .o_irq      (o_irq)
  );

  int tests = 0;
  int fails = 0;

  // Reference timer state, advanced once per clock by the driver.
  logic [63:0] m_mtime, m_cmp;
  logic        m_en, m_irqen, m_match, m_irq;
  int unsigned m_presc, m_phase;
  logic [31:0] m_snap;

  logic [31:0] exp_q[$];
  logic        rd_vld;
  logic [31:0] exp_word;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  task automatic model_reset();
    m_mtime = 64'd0;
    m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
    m_en    = 1'b0;
    m_irqen = 1'b0;
    m_presc = 0;
    m_phase = 0;
    m_match = 1'b0;
    m_irq   = 1'b0;
    m_snap  = 32'd0;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return m_mtime[31:0];
      3'd1:    return m_snap;
      3'd2:    return m_cmp[31:0];
      3'd3:    return m_cmp[63:32];
      3'd4:    return (32'(m_presc) << 8) | (32'(m_irqen) << 1) | 32'(m_en);
      3'd5:    return {31'd0, m_match};
      default: return 32'd0;
    endcase
  endfunction

  // One bus cycle: drive, predict, step the model at the edge. Entered at posedge+1.
  task automatic cycle(input logic cs, input logic rd, input logic wr, input logic [2:0] a,
                       input logic [31:0] d, input logic use_c, input logic [31:0] cval);
    logic        we, re, tick, cmp_true;
    logic [63:0] n_mtime, n_cmp;
    logic        n_en, n_irqen, n_match, n_irq;
    int unsigned n_presc, n_phase;
    logic [31:0] n_snap;
    i_cs = cs; i_rd = rd; i_wr = wr; i_addr = a; i_data_in = d;
    we = cs & wr;
    re = cs & rd;
    tick     = m_en && ((m_phase % (m_presc + 1)) == m_presc);
    cmp_true = (m_mtime >= m_cmp);
    if (re) exp_q.push_back(use_c ? cval : model_read(a));
    n_mtime = tick ? m_mtime + 64'd1 : m_mtime;
    if (we && a == 3'd0) n_mtime = {m_mtime[63:32], d};
    if (we && a == 3'd1) n_mtime = {d, m_mtime[31:0]};
    n_cmp = m_cmp;
    if (we && a == 3'd2) n_cmp[31:0]  = d;
    if (we && a == 3'd3) n_cmp[63:32] = d;
    n_en = m_en; n_irqen = m_irqen; n_presc = m_presc;
    if (we && a == 3'd4) begin
      n_en = d[0]; n_irqen = d[1]; n_presc = int'(d[15:8]);
    end
    n_phase = ((we && a == 3'd4) || !m_en) ? 0 : m_phase + 1;
    n_match = cmp_true ? 1'b1 : ((we && a == 3'd5 && d[0]) ? 1'b0 : m_match);
    n_irq   = m_irqen & cmp_true;
    n_snap  = (we && a == 3'd1) ? d : ((re && a == 3'd0) ? m_mtime[63:32] : m_snap);
    @(posedge i_clk);
    m_mtime = n_mtime; m_cmp = n_cmp; m_en = n_en; m_irqen = n_irqen; m_presc = n_presc;
    m_phase = n_phase; m_match = n_match; m_irq = n_irq; m_snap = n_snap;
    #1;
    i_cs = 1'b0; i_rd = 1'b0; i_wr = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    cycle(1'b1, 1'b0, 1'b1, a, d, 1'b0, 32'd0);
  endtask

  task automatic rdc(input logic [2:0] a, input logic [31:0] v);
    cycle(1'b1, 1'b1, 1'b0, a, 32'd0, 1'b1, v);
  endtask

  always @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) rd_vld <= 1'b0;
    else        rd_vld <= i_cs & i_rd;
  end

  // Monitor: read data pops the scoreboard; irq is compared every cycle.
  always @(negedge i_clk) begin
    if (i_rst) begin
      if (rd_vld) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL rd_underflow: got %h expected no read", o_data_out);
        end else begin
          exp_word = exp_q.pop_front();
          check("rd_data", 64'(o_data_out), 64'(exp_word));
        end
      end
      check("irq", 64'(o_irq), 64'(m_irq));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [2:0]  a;
    logic        cs, rd, wrs;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check("por_data_out", 64'(o_data_out), 64'd0);
    check("por_irq", 64'(o_irq), 64'd0);
    i_rst = 1'b1;

    rdc(3'd0, 32'd0);
    rdc(3'd1, 32'd0);
    rdc(3'd2, 32'hFFFF_FFFF);
    rdc(3'd3, 32'hFFFF_FFFF);
    rdc(3'd4, 32'd0);
    rdc(3'd5, 32'd0);

    // Prescale by 4: ten ticks in 40 cycles.
    wr(3'd4, 32'h0000_0301);
    idle(40);
    rdc(3'd0, 32'd10);
    wr(3'd4, 32'd0);

    // Coherent LO/HI pair across a low-word carry.
    wr(3'd0, 32'hFFFF_FFFE);
    wr(3'd1, 32'd0);
    wr(3'd4, 32'h0000_0001);
    rdc(3'd0, 32'hFFFF_FFFE);
    idle(5);
    rdc(3'd1, 32'd0);
    wr(3'd4, 32'd0);

    // Interrupt at mtime == 100, dropped by raising cmp_hi.
    wr(3'd1, 32'd0);
    wr(3'd0, 32'd0);
    wr(3'd3, 32'd0);
    wr(3'd2, 32'd100);
    wr(3'd0, 32'd90);
    wr(3'd4, 32'h0000_0003);
    idle(10);
    check("irq_before_match", 64'(o_irq), 64'd0);
    idle(1);
    check("irq_rise", 64'(o_irq), 64'd1);
    wr(3'd3, 32'd1);
    check("irq_write_edge", 64'(o_irq), 64'd1);
    idle(1);
    check("irq_drop", 64'(o_irq), 64'd0);
    rdc(3'd5, 32'd1);
    wr(3'd5, 32'd1);
    rdc(3'd5, 32'd0);
    wr(3'd4, 32'd0);

    // Write beats tick; set beats W1C.
    wr(3'd4, 32'h0000_0001);
    wr(3'd0, 32'd5);
    rdc(3'd0, 32'd5);
    wr(3'd4, 32'd0);
    wr(3'd3, 32'd0);
    wr(3'd2, 32'd0);
    wr(3'd5, 32'd1);
    rdc(3'd5, 32'd1);

    // Full 64-bit wrap.
    wr(3'd1, 32'hFFFF_FFFF);
    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd4, 32'h0000_0001);
    wr(3'd4, 32'd0);
    wr(3'd5, 32'd1);
    rdc(3'd5, 32'd1);
    rdc(3'd0, 32'd0);
    rdc(3'd1, 32'd0);

    // Asynchronous reset in the middle of counting.
    wr(3'd4, 32'h0000_0003);
    idle(3);
    rdc(3'd4, 32'h0000_0003);
    idle(1);
    check("pre_reset_irq", 64'(o_irq), 64'd1);
    check("pre_reset_data", 64'(o_data_out), 64'd3);
    #1;
    i_rst = 1'b0;
    model_reset();
    #1;
    check("rst_irq", 64'(o_irq), 64'd0);
    check("rst_data_out", 64'(o_data_out), 64'd0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    rdc(3'd0, 32'd0);
    rdc(3'd1, 32'd0);
    rdc(3'd2, 32'hFFFF_FFFF);
    rdc(3'd3, 32'hFFFF_FFFF);
    rdc(3'd4, 32'd0);
    rdc(3'd5, 32'd0);

    // Randomised traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      cs  = ($urandom_range(0, 4) != 0);
      rd  = $urandom_range(0, 1);
      wrs = ($urandom_range(0, 2) == 0);
      a   = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0:       d = 32'd0;
        1:       d = 32'hFFFF_FFFF;
        2:       d = 32'($urandom_range(0, 8));
        3:       d = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
        default: d = $urandom;
      endcase
      if (a == 3'd4) begin
        d[15:8] = 8'($urandom_range(0, 3));
        d[0]    = ($urandom_range(0, 3) != 0);
      end
      cycle(cs, rd, wrs, a, d, 1'b0, 32'd0);
    end

    idle(2);
    check("queue_drain", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
